cpu_mem_arbiter: RTL and testbench

Shares one single-port synchronous memory between the full_cpu instruction-fetch port and its load/store port. Each side uses a valid/ready request and a one-cycle response pulse. The block is non-pipelined: one transaction in flight at a time, sequenced by a small FSM with a latency counter. Arbitration is data-priority with a fetch anti-starvation limit.

---
 rtl/cpu_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - fetch/load-store arbiter for one single-port synchronous memory
// Define CPU_MEM_ARB_ROUND_ROBIN_EN to replace data-priority/starvation arbitration with round-robin.
module cpu_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_be,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [3:0]          lat_cnt;
    logic                owner_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                we_q;
    logic                idle;
    logic                grant_d;
    logic                grant_if;
    logic                hs;

    assign idle = (state == IDLE);

`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
    // Remembers which side won the previous handshake; 1 = data.
    logic last_grant_d;

    assign grant_d = d_req_valid && !(if_req_valid && last_grant_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_d <= 1'b1;
        end else if (hs) begin
            last_grant_d <= grant_d;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;

    assign grant_d = d_req_valid && !(if_req_valid && starve_cnt == STARVE_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (idle) begin
            if (!if_req_valid || grant_if) begin
                starve_cnt <= 4'd0;
            end else if (hs && starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

    assign grant_if     = if_req_valid && !grant_d;
    assign hs           = idle && (grant_d || grant_if);
    // Readies are gated by reset so every output reads 0 while reset is held.
    assign if_req_ready = reset && idle && grant_if;
    assign d_req_ready  = reset && idle && grant_d;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lat_cnt     <= 4'd0;
            owner_d     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            if_rsp_data <= '0;
            d_rsp_data  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (hs) begin
                        owner_d <= grant_d;
                        addr_q  <= grant_d ? d_req_addr : if_req_addr;
                        wdata_q <= grant_d ? d_req_wdata : '0;
                        be_q    <= grant_d ? d_req_be : '0;
                        we_q    <= grant_d && d_req_we;
                    end
                end
                ISSUE: lat_cnt <= LAT_INIT;
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        if (owner_d) begin
                            d_rsp_data <= we_q ? '0 : mem_rdata;
                        end else begin
                            if_rsp_data <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en       = (state == ISSUE);
        mem_we       = (mem_en && we_q) ? be_q : '0;
        mem_addr     = mem_en ? addr_q : '0;
        mem_wdata    = mem_en ? wdata_q : '0;
        if_rsp_valid = (state == RESP) && !owner_d;
        d_rsp_valid  = (state == RESP) && owner_d;
        busy         = !idle;
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - directed self-checking bench for cpu_mem_arbiter (MEM_LAT 1 and 3 instances)
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_be;

    logic        if_req_ready1, if_rsp_valid1, d_req_ready1, d_rsp_valid1, mem_en1, busy1;
    logic [31:0] if_rsp_data1, d_rsp_data1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [3:0]  mem_we1;
    logic        if_req_ready2, if_rsp_valid2, d_req_ready2, d_rsp_valid2, mem_en2, busy2;
    logic [31:0] if_rsp_data2, d_rsp_data2, mem_addr2, mem_wdata2, mem_rdata2;
    logic [3:0]  mem_we2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready1),
        .if_rsp_valid(if_rsp_valid1), .if_rsp_data(if_rsp_data1),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready1),
        .d_rsp_valid(d_rsp_valid1), .d_rsp_data(d_rsp_data1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut2 (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready2),
        .if_rsp_valid(if_rsp_valid2), .if_rsp_data(if_rsp_data2),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready2),
        .d_rsp_valid(d_rsp_valid2), .d_rsp_data(d_rsp_data2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .busy(busy2)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory models: read data is valid only in the cycle exactly MEM_LAT after mem_en.
    logic        v1 = 1'b0;
    logic [31:0] a1 = '0;
    logic [2:0]  v2 = '0;
    logic [31:0] a2 [3];

    always @(posedge clk) begin
        v1    <= mem_en1 && (mem_we1 == 4'h0);
        a1    <= mem_addr1;
        v2    <= {v2[1:0], mem_en2 && (mem_we2 == 4'h0)};
        a2[0] <= mem_addr2;
        a2[1] <= a2[0];
        a2[2] <= a2[1];
    end

    assign mem_rdata1 = v1 ? mem_f(a1) : 32'hBAD0_BAD0;
    assign mem_rdata2 = v2[2] ? mem_f(a2[2]) : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int last_t;
        int k;
        int seen;
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
        bit exp_d [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        bit exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
        reset = 1'b0;
        if_req_valid = 1'b0; if_req_addr = '0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_req_be = '0;

        // 1: reset with random requests, then release
        for (int i = 0; i < 3; i++) begin
            cyc();
            if_req_valid = 1'($urandom); if_req_addr = $urandom;
            d_req_valid = 1'($urandom); d_req_we = 1'($urandom); d_req_addr = $urandom;
            d_req_wdata = $urandom; d_req_be = 4'($urandom);
            #1;
            chk("rst_outs_lat1", 32'(|{if_req_ready1, if_rsp_valid1, if_rsp_data1, d_req_ready1, d_rsp_valid1,
                d_rsp_data1, mem_en1, mem_we1, mem_addr1, mem_wdata1, busy1}), 0);
            chk("rst_outs_lat3", 32'(|{if_req_ready2, if_rsp_valid2, if_rsp_data2, d_req_ready2, d_rsp_valid2,
                d_rsp_data2, mem_en2, mem_we2, mem_addr2, mem_wdata2, busy2}), 0);
        end
        cyc();
        reset = 1'b1;
        if_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
        #1 chk("idle_no_req_readies", {if_req_ready1, d_req_ready1}, 2'b00);
        d_req_valid = 1'b1;
        #1 chk("idle_d_only_readies", {if_req_ready1, d_req_ready1}, 2'b01);
        d_req_valid = 1'b0; if_req_valid = 1'b1;
        #1 chk("idle_if_only_readies", {if_req_ready1, d_req_ready1}, 2'b10);
        if_req_valid = 1'b0;
        #1 chk("idle_busy", busy1, 0);

        // 2: single fetch, MEM_LAT=1
        cyc();
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        #1 chk("t2_if_ready", if_req_ready1, 1);
        cyc();
        if_req_valid = 1'b0;
        chk("t2_c1_mem_en", mem_en1, 1);
        chk("t2_c1_mem_addr", mem_addr1, 32'h10);
        chk("t2_c1_mem_we", mem_we1, 0);
        chk("t2_c1_busy", busy1, 1);
        cyc();
        chk("t2_c2_mem_en", mem_en1, 0);
        chk("t2_c2_mem_addr", mem_addr1, 0);
        chk("t2_c2_busy", busy1, 1);
        chk("t2_c2_rsp_valid", if_rsp_valid1, 0);
        cyc();
        chk("t2_c3_rsp_valid", if_rsp_valid1, 1);
        chk("t2_c3_rsp_data", if_rsp_data1, 32'h0050_0093);
        chk("t2_c3_busy", busy1, 1);
        chk("t2_c3_d_rsp_valid", d_rsp_valid1, 0);
        cyc();
        chk("t2_c4_rsp_valid", if_rsp_valid1, 0);
        chk("t2_c4_busy", busy1, 0);

        // 3: simultaneous requests, data wins, fetch follows
        if_req_valid = 1'b1; if_req_addr = 32'h14;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h200;
        #1 chk("t3_readies", {if_req_ready1, d_req_ready1}, 2'b01);
        cyc();
        d_req_valid = 1'b0;
        cyc();
        cyc();
        chk("t3_d_rsp_valid", d_rsp_valid1, 1);
        chk("t3_d_rsp_data", d_rsp_data1, 32'hA5A5_0200);
        chk("t3_resp_if_ready", if_req_ready1, 0);
        cyc();
        chk("t3_if_ready_after", if_req_ready1, 1);
        cyc();
        if_req_valid = 1'b0;
        cyc();
        cyc();
        chk("t3_if_rsp_valid", if_rsp_valid1, 1);
        chk("t3_if_rsp_data", if_rsp_data1, 32'hA5A5_0014);
        chk("t3_d_rsp_data_hold", d_rsp_data1, 32'hA5A5_0200);
        cyc();

        // 4: both held high, starvation limit / round-robin order
        if_req_valid = 1'b1; if_req_addr = 32'h20;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h300;
        #1;
        t = 0;
        last_t = 0;
        for (int g = 0; g < 6; g++) begin
            k = 0;
            while (!(if_req_ready1 || d_req_ready1) && k < 12) begin
                cyc();
                k++;
                t++;
            end
            chk($sformatf("t4_grant%0d_seen", g), 32'(if_req_ready1 || d_req_ready1), 1);
            chk($sformatf("t4_grant%0d_is_data", g), 32'(d_req_ready1), 32'(exp_d[g]));
            if (g > 0) chk($sformatf("t4_grant%0d_spacing", g), t - last_t, 4);
            last_t = t;
            cyc();
            t++;
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        k = 0;
        while (busy1 && k < 10) begin
            cyc();
            k++;
        end
        chk("t4_drain_idle", busy1, 0);

        // 5: stores
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h100;
        d_req_wdata = 32'hDEAD_BEEF; d_req_be = 4'hF;
        #1 chk("t5_d_ready", d_req_ready1, 1);
        cyc();
        d_req_valid = 1'b0;
        chk("t5_mem_en", mem_en1, 1);
        chk("t5_mem_we", mem_we1, 4'hF);
        chk("t5_mem_wdata", mem_wdata1, 32'hDEAD_BEEF);
        chk("t5_mem_addr", mem_addr1, 32'h100);
        cyc();
        chk("t5_mem_we_off", mem_we1, 0);
        chk("t5_mem_wdata_off", mem_wdata1, 0);
        cyc();
        chk("t5_d_rsp_valid", d_rsp_valid1, 1);
        chk("t5_d_rsp_data", d_rsp_data1, 0);
        cyc();
        d_req_valid = 1'b1; d_req_addr = 32'h104; d_req_wdata = 32'h1234_5678; d_req_be = 4'h3;
        #1 chk("t5b_d_ready", d_req_ready1, 1);
        cyc();
        d_req_valid = 1'b0; d_req_we = 1'b0;
        chk("t5b_mem_we", mem_we1, 4'h3);
        chk("t5b_mem_wdata", mem_wdata1, 32'h1234_5678);
        cyc();
        cyc();
        cyc();

        // 6: MEM_LAT=3, reset during WAIT abandons the load
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h80;
        #1 chk("t6_d_ready", d_req_ready2, 1);
        cyc();
        d_req_valid = 1'b0;
        chk("t6_issue_mem_en", mem_en2, 1);
        chk("t6_issue_mem_addr", mem_addr2, 32'h80);
        cyc();
        chk("t6_wait_busy", busy2, 1);
        reset = 1'b0;
        #1 chk("t6_reset_outs", {mem_en2, busy2, d_rsp_valid2}, 3'b000);
        cyc();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (d_rsp_valid2) seen++;
            cyc();
        end
        chk("t6_no_abandoned_rsp", seen, 0);
        d_req_valid = 1'b1; d_req_addr = 32'h40;
        #1 chk("t6_new_d_ready", d_req_ready2, 1);
        cyc();
        d_req_valid = 1'b0;
        k = 1;
        while (!d_rsp_valid2 && k < 12) begin
            cyc();
            k++;
        end
        chk("t6_rsp_latency", k, 5);
        chk("t6_rsp_valid", d_rsp_valid2, 1);
        chk("t6_rsp_data", d_rsp_data2, 32'hA5A5_0040);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
